// File: rtl/uart_pkg.sv
// Shared definitions for the oversampled UART receiver: receiver states, data width
// and the constant functions that size the baud-tick phase accumulator.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    // Wide enough that the tick-period error stays well below one percent.
    function automatic int acc_width(input longint clk_freq, input longint baud);
        return $clog2(clk_freq / baud) + 8;
    endfunction

    function automatic longint acc_increment(input longint clk_freq, input longint baud,
                                             input longint oversampling, input int width);
        longint num;
        num = (baud * oversampling) << width;
        return (num + clk_freq / 2) / clk_freq;
    endfunction

endpackage

// File: rtl/uart_rx_tickgen.sv
// Free-running phase accumulator producing a one-clock tick at Baud*Oversampling.
// The tick is the registered carry out of the accumulator.
module uart_rx_tickgen
    import uart_pkg::*;
#(
    parameter int ClkFrequency = 50000000,
    parameter int Baud         = 115200,
    parameter int Oversampling = 8
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int acc_bits = acc_width(longint'(ClkFrequency), longint'(Baud));
    localparam longint acc_step = acc_increment(longint'(ClkFrequency), longint'(Baud),
                                                longint'(Oversampling), acc_bits);
    localparam logic [acc_bits:0] inc = acc_step[acc_bits:0];

    logic [acc_bits:0] acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else begin
            acc <= {1'b0, acc[acc_bits-1:0]} + inc;
        end
    end

    assign tick = acc[acc_bits];

endmodule

// File: rtl/uart_rx_oversampled.sv
// 8N1 LSB-first UART receiver with 2-flop synchroniser, 3-sample majority voter,
// mid-stop-bit decision, framing-error/break handling and a line-idle detector.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int ClkFrequency = 50000000,
    parameter int Baud         = 115200,
    parameter int Oversampling = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      RxD,
    output logic [UART_DATA_BITS-1:0] RxD_data,
    output logic                      RxD_data_ready,
    output logic                      RxD_frame_err,
    output logic                      RxD_busy,
    output logic                      RxD_idle
);

    localparam logic [3:0] cnt_half   = 4'(Oversampling / 2 - 1);
    localparam logic [3:0] cnt_full   = 4'(Oversampling - 1);
    localparam logic [2:0] idx_last   = 3'(UART_DATA_BITS - 1);
    localparam int         phase_bits = $clog2(Oversampling);
    localparam logic [phase_bits-1:0] phase_last = phase_bits'(Oversampling - 1);

    logic                      tick;
    logic                      sync1;
    logic                      sync2;
    logic [2:0]                samples;
    logic                      maj;
    rx_state_t                 state;
    rx_state_t                 state_next;
    logic [3:0]                cnt;
    logic [2:0]                idx;
    logic [UART_DATA_BITS-1:0] shift;
    logic [phase_bits-1:0]     phase;
    logic [7:0]                high_bits;
    logic                      cnt_clear;
    logic                      cnt_inc;
    logic                      idx_clear;
    logic                      shift_en;
    logic                      data_load;
    logic                      err_set;

    uart_rx_tickgen #(
        .ClkFrequency (ClkFrequency),
        .Baud         (Baud),
        .Oversampling (Oversampling)
    ) u_tickgen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            samples <= 3'b111;
        end else begin
            sync1 <= RxD;
            sync2 <= sync1;
            if (tick) begin
                samples <= {samples[1:0], sync2};
            end
        end
    end

    assign maj = (samples[0] & samples[1]) | (samples[1] & samples[2]) | (samples[0] & samples[2]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (tick) begin
            case (state)
                ST_IDLE:  if (!sync2) state_next = ST_START;
                ST_START: if (cnt == cnt_half) state_next = maj ? ST_IDLE : ST_DATA;
                ST_DATA:  if (cnt == cnt_full && idx == idx_last) state_next = ST_STOP;
                ST_STOP:  if (cnt == cnt_full) state_next = maj ? ST_IDLE : ST_BREAK;
                ST_BREAK: if (maj) state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        RxD_busy  = (state != ST_IDLE);
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        idx_clear = 1'b0;
        shift_en  = 1'b0;
        data_load = 1'b0;
        err_set   = 1'b0;
        if (tick) begin
            case (state)
                ST_START: begin
                    if (cnt == cnt_half) begin
                        cnt_clear = 1'b1;
                        idx_clear = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == cnt_full) begin
                        cnt_clear = 1'b1;
                        shift_en  = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt == cnt_full) begin
                        cnt_clear = 1'b1;
                        data_load = maj;
                        err_set   = !maj;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                default: cnt_clear = 1'b1;
            endcase
        end
    end

    // Strobes are registered straight from the decision, so they self-clear next clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt            <= '0;
            idx            <= '0;
            shift          <= '0;
            RxD_data       <= '0;
            RxD_data_ready <= 1'b0;
            RxD_frame_err  <= 1'b0;
        end else begin
            RxD_data_ready <= data_load;
            RxD_frame_err  <= err_set;
            if (cnt_clear) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 4'd1;
            end
            if (idx_clear) begin
                idx <= '0;
            end else if (shift_en) begin
                idx <= idx + 3'd1;
            end
            if (shift_en) begin
                shift <= {maj, shift[UART_DATA_BITS-1:1]};
            end
            if (data_load) begin
                RxD_data <= shift;
            end
        end
    end

    // Bit phase realigns on every low sample, so high-bit counts land near bit centres.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase     <= '0;
            high_bits <= '0;
        end else if (tick) begin
            if (!maj) begin
                phase     <= '0;
                high_bits <= '0;
            end else begin
                phase <= phase + phase_bits'(1);
                if (phase == phase_last && high_bits != 8'hFF) begin
                    high_bits <= high_bits + 8'd1;
                end
            end
        end
    end

    assign RxD_idle = (high_bits >= 8'd10);

endmodule
